// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
//
// Hardwired control unit for the bus-based datapath. It sequences the fetch,
// decode and execute phases of three-register ALU instructions and drives
// every datapath strobe.
//
// Instruction word: opcode ir[31:27], Ra ir[26:23] (dest), Rb ir[22:19],
// Rc ir[18:15]. Legal opcodes: add 00011, sub 00100, and 01001, or 01010,
// halt 11011. Every other opcode raises an illegal-opcode fault.
//
// State flow: IDLE -> T0 -> T1 (memory wait) -> T2 -> DEC -> T3 -> T4 -> T5 -> T0.
// DEC branches to HALT on halt or on an illegal opcode. A memory timeout in
// T1 also goes to HALT. HALT is left only through reset.
//
// All outputs are registered (Moore). The strobes for a state are computed
// from the next state and loaded on the same edge that enters that state.
// Each strobe is therefore high for exactly the cycles spent in its state.
// The fetch strobes of T0 depend on run. run is sampled on the edge that
// enters or holds T0. A T0 cycle with strobes always moves on to T1. A T0
// cycle without strobes re-samples run on its closing edge.
//
// Optional feature (macro CTRL_SEQUENCER_STEP_EN): adds a 1-bit input, step.
// T0 then fires only when run=1 and step=1 are seen together. A step input
// held high runs instructions back to back.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   run        in   level; fetch the next instruction from T0
//   step       in   (CTRL_SEQUENCER_STEP_EN only) single-step qualifier
//   ir[31:0]   in   IR contents from the datapath
//   mem_ready  in   memory data valid
//   pc_out, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in, y_in, z_in,
//   z_low_out  out  datapath strobes
//   gpr_in     out  one-hot register write enable  [NUM_REGS-1:0]
//   gpr_out    out  one-hot register bus drive     [NUM_REGS-1:0]
//   alu_op     out  ALU operation, equal to ir[31:27] in T4, 0 otherwise
//   busy       out  1 in any state other than IDLE/HALT
//   halted     out  1 in HALT
//   fault      out  00 none, 01 illegal opcode, 10 memory timeout (sticky)
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
    parameter int NUM_REGS     = 16,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
`ifdef CTRL_SEQUENCER_STEP_EN
    input  logic                step,
`endif
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                pc_out,
    output logic                inc_pc,
    output logic                mar_in,
    output logic                read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                z_low_out,
    output logic [NUM_REGS-1:0] gpr_in,
    output logic [NUM_REGS-1:0] gpr_out,
    output logic [4:0]          alu_op,
    output logic                busy,
    output logic                halted,
    output logic [1:0]          fault
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_DEC  = 4'd4;
    localparam logic [3:0] S_T3   = 4'd5;
    localparam logic [3:0] S_T4   = 4'd6;
    localparam logic [3:0] S_T5   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);
    // The last waiting T1 cycle is number MEM_WAIT_MAX. The counter holds the
    // number of cycles already waited, so the timeout fires at MAX-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0]       fault_reg, fault_next;

    logic pc_out_reg, inc_pc_reg, mar_in_reg, read_reg, mdr_in_reg;
    logic mdr_out_reg, ir_in_reg, y_in_reg, z_in_reg, z_low_out_reg;
    logic busy_reg, halted_reg;
    logic [4:0] alu_op_reg, alu_op_next;
    logic [NUM_REGS-1:0] gpr_in_reg, gpr_in_next;
    logic [NUM_REGS-1:0] gpr_out_reg, gpr_out_next;
    logic fetch_next;

    wire [4:0] opcode = ir[31:27];
    wire [3:0] ra     = ir[26:23];
    wire [3:0] rb     = ir[22:19];
    wire [3:0] rc     = ir[18:15];

    // Fetch request that qualifies the T0 strobes.
    logic fetch_req;
`ifdef CTRL_SEQUENCER_STEP_EN
    assign fetch_req = run & step;
`else
    assign fetch_req = run;
`endif

    // Next-state, wait counter and sticky fault.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        fault_next    = fault_reg;
        case (state_reg)
            S_IDLE: state_next = S_T0;
            // pc_out_reg marks a T0 cycle that has already issued its strobes.
            S_T0:   if (pc_out_reg) state_next = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    state_next    = S_T2;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == CNT_LAST) begin
                    state_next    = S_HALT;
                    fault_next    = FAULT_TIMEOUT;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_T2:   state_next = S_DEC;
            S_DEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = S_T3;
                    OP_HALT: state_next = S_HALT;
                    default: begin
                        state_next = S_HALT;
                        fault_next = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_T3:   state_next = S_T4;
            S_T4:   state_next = S_T5;
            S_T5:   state_next = S_T0;
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // A T0 entered or held with a fetch request issues the fetch strobes.
    assign fetch_next  = (state_next == S_T0) && fetch_req;
    assign alu_op_next = (state_next == S_T4) ? opcode : 5'd0;

    // Register selects. Each phase decodes exactly one field, so each vector
    // stays one-hot even when Ra aliases Rb or Rc.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_gpr_sel
            assign gpr_out_next[gi] = ((state_next == S_T3) && (rb == 4'(gi)))
                                   || ((state_next == S_T4) && (rc == 4'(gi)));
            assign gpr_in_next[gi]  = (state_next == S_T5) && (ra == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            wait_cnt_reg  <= '0;
            fault_reg     <= FAULT_NONE;
            pc_out_reg    <= 1'b0;
            inc_pc_reg    <= 1'b0;
            mar_in_reg    <= 1'b0;
            read_reg      <= 1'b0;
            mdr_in_reg    <= 1'b0;
            mdr_out_reg   <= 1'b0;
            ir_in_reg     <= 1'b0;
            y_in_reg      <= 1'b0;
            z_in_reg      <= 1'b0;
            z_low_out_reg <= 1'b0;
            alu_op_reg    <= 5'd0;
            gpr_in_reg    <= '0;
            gpr_out_reg   <= '0;
            busy_reg      <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            fault_reg     <= fault_next;
            pc_out_reg    <= fetch_next;
            inc_pc_reg    <= fetch_next;
            mar_in_reg    <= fetch_next;
            read_reg      <= (state_next == S_T1);
            mdr_in_reg    <= (state_next == S_T1);
            mdr_out_reg   <= (state_next == S_T2);
            ir_in_reg     <= (state_next == S_T2);
            y_in_reg      <= (state_next == S_T3);
            z_in_reg      <= (state_next == S_T4);
            z_low_out_reg <= (state_next == S_T5);
            alu_op_reg    <= alu_op_next;
            gpr_in_reg    <= gpr_in_next;
            gpr_out_reg   <= gpr_out_next;
            busy_reg      <= (state_next != S_IDLE) && (state_next != S_HALT);
            halted_reg    <= (state_next == S_HALT);
        end
    end

    assign pc_out    = pc_out_reg;
    assign inc_pc    = inc_pc_reg;
    assign mar_in    = mar_in_reg;
    assign read      = read_reg;
    assign mdr_in    = mdr_in_reg;
    assign mdr_out   = mdr_out_reg;
    assign ir_in     = ir_in_reg;
    assign y_in      = y_in_reg;
    assign z_in      = z_in_reg;
    assign z_low_out = z_low_out_reg;
    assign alu_op    = alu_op_reg;
    assign gpr_in    = gpr_in_reg;
    assign gpr_out   = gpr_out_reg;
    assign busy      = busy_reg;
    assign halted    = halted_reg;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, mem_ready;
    logic [31:0] ir;
`ifdef CTRL_SEQUENCER_STEP_EN
    logic        step = 1'b1;
`endif
    logic        pc_out, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, z_low_out, busy, halted;
    logic [15:0] gpr_in, gpr_out;
    logic [4:0]  alu_op;
    logic [1:0]  fault;

    ctrl_sequencer #(.NUM_REGS(16), .MEM_WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .run(run),
`ifdef CTRL_SEQUENCER_STEP_EN
        .step(step),
`endif
        .ir(ir), .mem_ready(mem_ready),
        .pc_out(pc_out), .inc_pc(inc_pc), .mar_in(mar_in), .read(read),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
        .z_in(z_in), .z_low_out(z_low_out), .gpr_in(gpr_in), .gpr_out(gpr_out),
        .alu_op(alu_op), .busy(busy), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // Strobe vector: {pc_out,inc_pc,mar_in,read,mdr_in,mdr_out,ir_in,y_in,z_in,z_low_out}
    wire [9:0]  strb    = {pc_out, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in, y_in, z_in, z_low_out};
    wire [50:0] all_out = {fault, halted, busy, alu_op, gpr_in, gpr_out, strb};

    localparam logic [9:0] ST_NONE = 10'b0000000000;
    localparam logic [9:0] ST_T0   = 10'b1110000000;
    localparam logic [9:0] ST_T1   = 10'b0001100000;
    localparam logic [9:0] ST_T2   = 10'b0000011000;
    localparam logic [9:0] ST_T3   = 10'b0000000100;
    localparam logic [9:0] ST_T4   = 10'b0000000010;
    localparam logic [9:0] ST_T5   = 10'b0000000001;

    localparam logic [31:0] IR_AND  = 32'h4A92_0000; // and R5,R2,R4
    localparam logic [31:0] IR_ADD  = 32'h189B_8000; // add R1,R3,R7
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int pc_seen;
        int gin_seen;

        // ---------------- reset + and R5,R2,R4 --------------------------
        reset = 1'b1; run = 1'b1; mem_ready = 1'b1; ir = IR_AND;
        tick(); tick();
        check_eq("reset_all_zero", 64'(all_out), 64'd0);
        reset = 1'b0;
        tick();                                   // T0
        check_eq("and_t0_strb", 64'(strb), 64'(ST_T0));
        check_eq("and_t0_busy", 64'(busy), 64'd1);
        tick();                                   // T1
        check_eq("and_t1_strb", 64'(strb), 64'(ST_T1));
        tick();                                   // T2
        check_eq("and_t2_strb", 64'(strb), 64'(ST_T2));
        run = 1'b0;                               // dropped mid-instruction
        tick();                                   // DEC
        check_eq("and_dec_strb", 64'(strb), 64'(ST_NONE));
        check_eq("and_dec_busy", 64'(busy), 64'd1);
        tick();                                   // T3
        check_eq("and_t3_strb", 64'(strb), 64'(ST_T3));
        check_eq("and_t3_gpr_out", 64'(gpr_out), 64'h0004);
        tick();                                   // T4
        run = 1'b1;
        check_eq("and_t4_strb", 64'(strb), 64'(ST_T4));
        check_eq("and_t4_gpr_out", 64'(gpr_out), 64'h0010);
        check_eq("and_t4_alu_op", 64'(alu_op), 64'b01001);
        tick();                                   // T5, 7th cycle from T0
        check_eq("and_t5_strb", 64'(strb), 64'(ST_T5));
        check_eq("and_t5_gpr_in", 64'(gpr_in), 64'h0020);
        check_eq("and_t5_gpr_out", 64'(gpr_out), 64'h0000);
        check_eq("and_t5_alu_op", 64'(alu_op), 64'd0);
        tick();                                   // T0 of next instruction
        check_eq("add_t0_strb", 64'(strb), 64'(ST_T0));

        // ---------------- add R1,R3,R7 with 3 wait cycles ---------------
        ir = IR_ADD; mem_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!read) break;
            n++;
            if (n == 4) mem_ready = 1'b1;
        end
        check_eq("add_read_cycles", 64'(n), 64'd4);
        check_eq("add_t2_strb", 64'(strb), 64'(ST_T2));
        tick();                                   // DEC
        tick();                                   // T3
        check_eq("add_t3_gpr_out", 64'(gpr_out), 64'h0008);
        tick();                                   // T4
        check_eq("add_t4_gpr_out", 64'(gpr_out), 64'h0080);
        check_eq("add_t4_alu_op", 64'(alu_op), 64'b00011);
        tick();                                   // T5
        check_eq("add_t5_gpr_in", 64'(gpr_in), 64'h0002);
        check_eq("add_t5_strb", 64'(strb), 64'(ST_T5));
        tick();                                   // T0

        // ---------------- halt ------------------------------------------
        ir = IR_HALT;
        tick(); tick(); tick();                   // T1, T2, DEC
        tick();                                   // HALT
        check_eq("halt_halted", 64'(halted), 64'd1);
        check_eq("halt_busy", 64'(busy), 64'd0);
        check_eq("halt_fault", 64'(fault), 64'd0);
        pc_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pc_out || strb != ST_NONE) pc_seen++;
        end
        check_eq("halt_no_strobes", 64'(pc_seen), 64'd0);

        // ---------------- illegal opcode --------------------------------
        reset = 1'b1; ir = IR_ILL; mem_ready = 1'b1;
        tick();
        reset = 1'b0;
        gin_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (gpr_in != 16'd0) gin_seen++;
        end
        check_eq("ill_fault", 64'(fault), 64'b01);
        check_eq("ill_halted", 64'(halted), 64'd1);
        check_eq("ill_no_gpr_in", 64'(gin_seen), 64'd0);

        // ---------------- memory timeout --------------------------------
        reset = 1'b1; ir = IR_AND; mem_ready = 1'b0;
        tick();
        check_eq("to_reset_fault_clr", 64'(fault), 64'd0);
        reset = 1'b0;
        tick();                                   // T0
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!read) break;
            n++;
        end
        check_eq("to_t1_cycles", 64'(n), 64'd15);
        check_eq("to_fault", 64'(fault), 64'b10);
        check_eq("to_halted", 64'(halted), 64'd1);

        // ---------------- reset during T4 -------------------------------
        reset = 1'b1; ir = IR_AND; mem_ready = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();       // T0 T1 T2 DEC T3 T4
        check_eq("rst4_in_t4", 64'(z_in), 64'd1);
        reset = 1'b1;
        tick();
        check_eq("rst4_all_zero", 64'(all_out), 64'd0);
        reset = 1'b0; run = 1'b0;
        tick();                                   // T0, no run
        check_eq("rst4_t0_idle_strb", 64'(strb), 64'(ST_NONE));
        check_eq("rst4_t0_busy", 64'(busy), 64'd1);
        tick();
        check_eq("rst4_t0_hold", 64'(pc_out), 64'd0);
        run = 1'b1;
        tick();
        check_eq("rst4_fetch", 64'(strb), 64'(ST_T0));
        tick();
        check_eq("rst4_t1", 64'(strb), 64'(ST_T1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Hardwired control unit for the bus-based datapath. It sequences fetch, decode and execute for three-register ALU instructions, and drives every datapath strobe (pc_out, mar_in, read, mdr_in, ir_in, y_in, z_in, z_low_out, gpr_in/gpr_out one-hots). It replaces the hand-timed stimulus used during bring-up and sits beside the datapath inside the CPU top level.

Parameters:
NUM_REGS, 16, number of GPRs; gpr_in/gpr_out width
MEM_WAIT_MAX, 15, maximum T1 wait cycles for mem_ready before fault

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; 1 = fetch next instruction when in T0
ir  in  32  IR contents from datapath
mem_ready  in  1  memory data valid on m_data_in
pc_out  out  1  drive PC onto bus
inc_pc  out  1  PC increment
mar_in  out  1  latch MAR
read  out  1  memory read request
mdr_in  out  1  latch MDR from memory
mdr_out  out  1  drive MDR onto bus
ir_in  out  1  latch IR
y_in  out  1  latch Y
z_in  out  1  latch Z
z_low_out  out  1  drive Z[31:0] onto bus
gpr_in  out  NUM_REGS  one-hot register write enable
gpr_out  out  NUM_REGS  one-hot register bus drive
alu_op  out  5  ALU operation, equal to ir[31:27] during T4
busy  out  1  1 in any state other than IDLE/HALT
halted  out  1  1 in HALT
fault  out  2  00 none, 01 illegal opcode, 10 memory timeout; sticky until reset

Behaviour:
- Reset is synchronous and active-high. At the edge with reset=1: state=IDLE, all outputs 0, wait counter 0, fault=00. Asserting reset mid-instruction aborts the instruction; there are no partial writes after that edge.
- Outputs are registered (Moore). Each strobe is high for exactly the cycle(s) of its state.
- IR format: opcode ir[31:27], Ra ir[26:23] (dest), Rb ir[22:19], Rc ir[18:15].
- Legal opcodes: add 00011, sub 00100, and 01001, or 01010, halt 11011. All other opcodes are illegal.
- IDLE: go to T0.
- T0: if run=1, assert pc_out, mar_in and inc_pc, then go to T1. If run=0, hold T0 with no strobes.
- T1: assert read and mdr_in every cycle. If mem_ready=1, go to T2. Otherwise increment the wait counter. When the counter reaches MEM_WAIT_MAX with mem_ready still 0, set fault=10 and go to HALT. The counter clears on leaving T1.
- T2: assert mdr_out and ir_in, then go to DEC.
- DEC: no strobes, one cycle. halt → HALT. Illegal → fault=01, then HALT. ALU op → T3.
- T3: assert gpr_out[Rb] and y_in.
- T4: assert gpr_out[Rc] and z_in; alu_op=opcode. alu_op is 0 in all other states.
- T5: assert z_low_out and gpr_in[Ra], then go to T0.
- HALT: all strobes 0, halted=1. Leave only on reset.
- ALU instruction latency is 7 cycles from T0 to T5 with zero memory wait, plus one cycle per wait.
- gpr_in/gpr_out are never multi-hot. When Ra equals Rb or Rc, each phase still drives a single bit. Ra=0 is written normally.
- run is sampled only in T0. Dropping run mid-instruction has no effect until the next T0.
- mdr_out and z_low_out are never high in the same cycle.

Optional Feature:
CTRL_SEQUENCER_STEP_EN. When defined, an extra input step (1 bit) is added. T0 additionally requires a step pulse: it advances only on a cycle with run=1 and step=1, so exactly one instruction runs per pulse. A step held high runs back-to-back instructions. When not defined, the port is absent and T0 advances on run alone.

Test Plan:
- run=1, mem_ready=1, ir=0x4A920000 (and R5,R2,R4) → T3 gpr_out=0x0004 with y_in; T4 gpr_out=0x0010, z_in, alu_op=01001; T5 gpr_in=0x0020 with z_low_out; 7 cycles T0→T5.
- ir=0x189B8000 (add R1,R3,R7), mem_ready delayed 3 cycles → read/mdr_in high 4 cycles; T3 gpr_out=0x0008, T4 gpr_out=0x0080, alu_op=00011, T5 gpr_in=0x0002.
- ir=0xD8000000 (halt) → HALT after DEC; halted=1, busy=0, no further pc_out while run=1.
- ir=0xF8000000 → fault=01, HALT; no gpr_in asserted.
- mem_ready held 0 → exactly MEM_WAIT_MAX=15 T1 cycles, then fault=10 and halted=1.
- reset=1 during T4 → next cycle all outputs 0, state IDLE; reset released → T0, and fetch resumes when run=1.
